// File: rtl/io_oser_cell.sv
// Fabric-to-pad output serializer: accepts a parallel word over valid/ready and
// drives it LSB-first onto the pad, with a static combinational bypass path.
module io_oser_cell #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic [WIDTH-1:0] A2F_D,
  input  logic             A2F_OE,
  input  logic             A2F_VALID,
  output logic             A2F_READY,
  input  logic             OSEL,
  output logic             IQZ,
  output logic             IQE,
  output logic             BUSY
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             oe_q;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt == LAST);

  // The pad always shows bit 0 of the shift register while a word is in
  // flight, so the first bit appears right after the accept edge.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    A2F_READY = 1'b1;
    IQZ       = IDLE_LEVEL;
    IQE       = 1'b0;
    BUSY      = 1'b0;
    if (OSEL) begin
      IQZ = A2F_D[0];
      IQE = A2F_OE;
    end else if (state == SHIFT) begin
      IQZ       = sreg[0];
      IQE       = oe_q;
      BUSY      = 1'b1;
      A2F_READY = last_bit;
    end
  end

  assign accept = A2F_VALID & A2F_READY & ~OSEL;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      oe_q  <= 1'b0;
    end else if (OSEL) begin
      // Bypass discards any in-flight word; serial path restarts from IDLE.
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      cnt   <= '0;
      sreg  <= A2F_D;
      oe_q  <= A2F_OE;
    end else if (state == SHIFT) begin
      if (last_bit) begin
        state <= IDLE;
      end else begin
        sreg <= sreg >> 1;
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_io_oser_cell.sv
// Randomized self-checking bench for io_oser_cell against a queue-of-pad-bits
// reference model: each accepted word becomes WIDTH {oe,bit} entries.
module tb_io_oser_cell;

  localparam int   W    = 4;
  localparam logic IDLE = 1'b0;

  logic         IQC = 1'b0;
  logic         QRT;
  logic [W-1:0] A2F_D;
  logic         A2F_OE;
  logic         A2F_VALID;
  logic         A2F_READY;
  logic         OSEL;
  logic         IQZ;
  logic         IQE;
  logic         BUSY;

  int checks   = 0;
  int failures = 0;
  bit clk_run  = 1'b1;

  logic [1:0] q[$];   // pending pad cycles, front = what the pad shows now

  io_oser_cell #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
    .IQC(IQC), .QRT(QRT), .A2F_D(A2F_D), .A2F_OE(A2F_OE),
    .A2F_VALID(A2F_VALID), .A2F_READY(A2F_READY), .OSEL(OSEL),
    .IQZ(IQZ), .IQE(IQE), .BUSY(BUSY)
  );

  always begin
    #5;
    if (clk_run) IQC = ~IQC;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected {IQZ, IQE, BUSY, A2F_READY} from the model and current inputs.
  function automatic logic [3:0] exp_out();
    if (!QRT)           return {IDLE, 1'b0, 1'b0, 1'b1};
    if (OSEL)           return {A2F_D[0], A2F_OE, 1'b0, 1'b1};
    if (q.size() == 0)  return {IDLE, 1'b0, 1'b0, 1'b1};
    return {q[0][0], q[0][1], 1'b1, q.size() == 1};
  endfunction

  function automatic logic [3:0] dut_out();
    return {IQZ, IQE, BUSY, A2F_READY};
  endfunction

  // One clock edge: model advances, outputs are settled 1 time unit later.
  task automatic tick();
    bit acc;
    acc = QRT && !OSEL && A2F_VALID && (q.size() <= 1);
    @(posedge IQC);
    if (!QRT || OSEL) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (acc) for (int i = 0; i < W; i++) q.push_back({A2F_OE, A2F_D[i]});
    end
    #1;
  endtask

  task automatic test_reset();
    QRT = 1'b0; A2F_VALID = 1'b1; A2F_D = 4'hF; A2F_OE = 1'b1; OSEL = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_out() !== 4'b0001) begin
        failures++;
        $display("FAIL reset_hold: got {iqz,iqe,busy,rdy}=%b expected 0001", dut_out());
      end
    end
    QRT = 1'b1; A2F_VALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dut_out() !== exp_out() || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL reset_release: got %b expected %b", dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] bits = 4'b1011;
    A2F_D = bits; A2F_OE = 1'b1; A2F_VALID = 1'b1;
    for (int i = 0; i < W + 1; i++) begin
      tick();
      A2F_VALID = 1'b0; A2F_D = 4'($urandom);
      checks++;
      if (dut_out() !== exp_out()) begin
        failures++;
        $display("FAIL single_word[%0d]: got %b expected %b", i, dut_out(), exp_out());
      end
      if (i < W) begin
        checks++;
        if (IQZ !== bits[i] || IQE !== 1'b1 || A2F_READY !== (i == W - 1)) begin
          failures++;
          $display("FAIL single_bit[%0d]: got iqz=%b iqe=%b rdy=%b expected iqz=%b iqe=1 rdy=%b",
                   i, IQZ, IQE, A2F_READY, bits[i], i == W - 1);
        end
      end
    end
  endtask

  task automatic run_pair(input string name, input logic [3:0] w0, input logic o0,
                          input logic [3:0] w1, input logic o1);
    logic [7:0] stream = {w1, w0};
    A2F_VALID = 1'b1; A2F_D = w0; A2F_OE = o0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (i == 0) begin A2F_D = w1; A2F_OE = o1; end
      if (i == W) A2F_VALID = 1'b0;
      checks++;
      if (dut_out() !== exp_out() || IQZ !== stream[i] || BUSY !== 1'b1 ||
          IQE !== ((i < W) ? o0 : o1)) begin
        failures++;
        $display("FAIL %s[%0d]: got %b expected %b (bit %b)", name, i, dut_out(), exp_out(), stream[i]);
      end
    end
    tick();
    checks++;
    if (dut_out() !== {IDLE, 3'b001}) begin
      failures++;
      $display("FAIL %s_end: got %b expected %b", name, dut_out(), {IDLE, 3'b001});
    end
  endtask

  task automatic test_back_to_back();
    run_pair("back_to_back", 4'hA, 1'b1, 4'h5, 1'b1);
  endtask

  task automatic test_oe_per_word();
    run_pair("oe_per_word", 4'h3, 1'b0, 4'hC, 1'b1);
  endtask

  task automatic test_reset_mid();
    A2F_VALID = 1'b1; A2F_D = 4'b0110; A2F_OE = 1'b1;
    tick(); A2F_VALID = 1'b0;
    tick();
    #2 QRT = 1'b0; q.delete();
    #1;
    checks++;
    if (dut_out() !== {IDLE, 3'b001}) begin
      failures++;
      $display("FAIL reset_mid_async: got %b expected %b", dut_out(), {IDLE, 3'b001});
    end
    tick();
    QRT = 1'b1; A2F_VALID = 1'b1; A2F_D = 4'b1001; A2F_OE = 1'b1;
    for (int i = 0; i < W + 1; i++) begin
      tick(); A2F_VALID = 1'b0;
      checks++;
      if (dut_out() !== exp_out()) begin
        failures++;
        $display("FAIL reset_mid_restart[%0d]: got %b expected %b", i, dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_osel_mid();
    A2F_VALID = 1'b1; A2F_D = 4'b1110; A2F_OE = 1'b1;
    tick(); A2F_VALID = 1'b0;
    tick();
    OSEL = 1'b1; A2F_VALID = 1'b1; A2F_D = 4'b0101; A2F_OE = 1'b0;
    #1;
    checks++;
    if (dut_out() !== 4'b1001) begin
      failures++;
      $display("FAIL osel_pulse_comb: got %b expected 1001", dut_out());
    end
    tick();
    OSEL = 1'b0; A2F_VALID = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_out() !== exp_out() || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL osel_discard[%0d]: got %b expected %b", i, dut_out(), exp_out());
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    OSEL = 1'b1; A2F_VALID = 1'b0;
    tick();
    clk_run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A2F_D  = {3'($urandom), i[0]};
      A2F_OE = i[1];
      #7;
      checks++;
      if (dut_out() !== {i[0], i[1], 2'b01}) begin
        failures++;
        $display("FAIL bypass_comb[%0d]: got %b expected %b", i, dut_out(), {i[0], i[1], 2'b01});
      end
    end
    clk_run = 1'b1;
    OSEL = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      A2F_VALID = ($urandom_range(0, 9) < 7);
      A2F_D     = 4'($urandom);
      A2F_OE    = ($urandom_range(0, 3) != 0);
      OSEL      = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (dut_out() !== exp_out()) begin
        failures++;
        $display("FAIL random_pre[%0d]: got %b expected %b", i, dut_out(), exp_out());
      end
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin
        failures++;
        $display("FAIL random_post[%0d]: got %b expected %b", i, dut_out(), exp_out());
      end
    end
    OSEL = 1'b0; A2F_VALID = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_oe_per_word();
    test_reset_mid();
    test_osel_mid();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
